// File: rtl/barrel_unrotator_seq.sv
// barrel_unrotator_seq: undoes a WIDTH-bit rotate one bit position per clock, with valid/ready on both sides
module barrel_unrotator_seq #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] w;
   logic [WIDTH-1:0] w_rot;
   logic [AMT_W-1:0] cnt;
   logic             dir;
   // Undo runs opposite to the forward rotate: forward right is undone by rotating left
   assign w_rot    = dir ? {w[WIDTH-2:0], w[WIDTH-1]} : {w[0], w[WIDTH-1:1]};
   assign in_ready = state == IDLE;
   assign busy     = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         w         <= '0;
         cnt       <= '0;
         dir       <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               w   <= in_data;
               cnt <= in_amt;
               dir <= in_ctrl;
               if (in_amt == '0) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               w   <= w_rot;
               cnt <= cnt - AMT_W'(1);
               // out_data is loaded only on the final step so it holds its value while shifting
               if (cnt == AMT_W'(1)) begin
                  out_data  <= w_rot;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
